// File: rtl/config_tx_sched_if.sv
// Host request, register-bank write port and serializer handshake of config_tx_sched.
// The master side is the host/serializer environment, the slave side is the sequencer.
interface config_tx_sched_if;
    logic        HOST_REQ;
    logic [2:0]  HOST_ADDR;
    logic [7:0]  HOST_DATA;
    logic        HOST_ACK;
    logic        REFRESH_EN;
    logic        ERR_CLR;
    logic        WE_A;
    logic [2:0]  ADD_A;
    logic [7:0]  DAT_A;
    logic        TX_START;
    logic        TX_END;
    logic        BUSY;
    logic        ERR;
    logic [15:0] TX_COUNT;

    modport master (
        output HOST_REQ, HOST_ADDR, HOST_DATA, REFRESH_EN, ERR_CLR, TX_END,
        input  HOST_ACK, WE_A, ADD_A, DAT_A, TX_START, BUSY, ERR, TX_COUNT
    );

    modport slave (
        input  HOST_REQ, HOST_ADDR, HOST_DATA, REFRESH_EN, ERR_CLR, TX_END,
        output HOST_ACK, WE_A, ADD_A, DAT_A, TX_START, BUSY, ERR, TX_COUNT
    );
endinterface

// File: rtl/config_tx_sched.sv
// Configuration-path sequencer: arbitrates host register writes against a periodic
// refresh, drives the serializer START level and supervises completion with timeout/retry.
module config_tx_sched #(
    parameter int REFRESH_CYCLES = 4800000,
    parameter int TIMEOUT_CYCLES = 480000,
    parameter int GAP_CYCLES     = 48,
    parameter int MAX_RETRY      = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    config_tx_sched_if.slave bus
);
    localparam int RFW = $clog2(REFRESH_CYCLES);
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    localparam int GPW = $clog2(GAP_CYCLES);
    localparam int RTW = $clog2(MAX_RETRY + 32'sd2);

    localparam logic [RFW-1:0] REFRESH_LAST = RFW'(REFRESH_CYCLES - 32'sd1);
    localparam logic [RFW-1:0] REFRESH_PRE  = RFW'(REFRESH_CYCLES - 32'sd2);
    // WAIT_END ends once the counter would reach TIMEOUT_CYCLES-1, so START
    // (ARM + WAIT_END) is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TOW-1:0] TIMEOUT_LAST = TOW'(TIMEOUT_CYCLES - 32'sd2);
    localparam logic [GPW-1:0] GAP_LAST     = GPW'(GAP_CYCLES - 32'sd1);
    localparam logic [RTW-1:0] RETRY_MAX    = RTW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_ARM      = 3'd2,
        S_WAIT_END = 3'd3,
        S_GAP      = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            end_q, end_d;
    logic            end_prev_q, end_prev_d;
    logic            end_edge_s;
    logic [RFW-1:0]  refresh_tmr_q, refresh_tmr_d;
    logic            refresh_due_q, refresh_due_d;
    logic [TOW-1:0]  tmo_q, tmo_d;
    logic [GPW-1:0]  gap_q, gap_d;
    logic [RTW-1:0]  retry_q, retry_d;
    logic            retry_pend_q, retry_pend_d;
    logic            err_q, err_d;
    logic [15:0]     tx_count_q, tx_count_d;
    logic            we_a_q, we_a_d;
    logic            host_ack_q, host_ack_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic [2:0]      add_a_q, add_a_d;
    logic [7:0]      dat_a_q, dat_a_d;
    logic            tx_ok_s, tx_retry_s, tx_abort_s;

    assign end_edge_s = end_q & ~end_prev_q;

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and transmission outcome strobes
    always_comb begin
        state_d    = state_q;
        tx_ok_s    = 1'b0;
        tx_retry_s = 1'b0;
        tx_abort_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.HOST_REQ) begin
                    state_d = S_WRITE;
                end else if (refresh_due_q) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: state_d = S_ARM;
            S_ARM:   state_d = S_WAIT_END;
            S_WAIT_END: begin
                // A completion edge in the timeout cycle still counts as success.
                if (end_edge_s) begin
                    tx_ok_s = 1'b1;
                    state_d = S_GAP;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    state_d = S_GAP;
                    if (retry_q < RETRY_MAX) begin
                        tx_retry_s = 1'b1;
                    end else begin
                        tx_abort_s = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT_END;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = retry_pend_q ? S_ARM : S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so every output is a flop
    always_comb begin
        we_a_d     = (state_d == S_WRITE);
        host_ack_d = (state_d == S_WRITE);
        tx_start_d = (state_d == S_ARM) || (state_d == S_WAIT_END);
        busy_d     = (state_d != S_IDLE);
        if (state_d == S_WRITE) begin
            add_a_d = bus.HOST_ADDR;
            dat_a_d = bus.HOST_DATA;
        end else begin
            add_a_d = add_a_q;
            dat_a_d = dat_a_q;
        end
    end

    // Counters, refresh timer, retry bookkeeping and sticky error
    always_comb begin
        end_d         = bus.TX_END;
        end_prev_d    = end_q;
        refresh_tmr_d = refresh_tmr_q;
        refresh_due_d = refresh_due_q;
        if (!bus.REFRESH_EN) begin
            refresh_tmr_d = {RFW{1'b0}};
            refresh_due_d = 1'b0;
        end else begin
            if (tx_ok_s) begin
                refresh_tmr_d = {RFW{1'b0}};
            end else if (refresh_tmr_q != REFRESH_LAST) begin
                refresh_tmr_d = refresh_tmr_q + RFW'(32'd1);
            end else begin
                refresh_tmr_d = refresh_tmr_q;
            end
            // Due is raised only on the step into saturation so an abort does not re-trigger it.
            if (state_q == S_ARM) begin
                refresh_due_d = 1'b0;
            end else if (!tx_ok_s && (refresh_tmr_q == REFRESH_PRE)) begin
                refresh_due_d = 1'b1;
            end else begin
                refresh_due_d = refresh_due_q;
            end
        end

        if (state_q == S_ARM) begin
            tmo_d = {TOW{1'b0}};
        end else if (state_q == S_WAIT_END) begin
            tmo_d = tmo_q + TOW'(32'd1);
        end else begin
            tmo_d = tmo_q;
        end

        if ((state_q == S_GAP) && (gap_q != GAP_LAST)) begin
            gap_d = gap_q + GPW'(32'd1);
        end else begin
            gap_d = {GPW{1'b0}};
        end

        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        if (tx_retry_s) begin
            retry_d      = retry_q + RTW'(32'd1);
            retry_pend_d = 1'b1;
        end else if (tx_ok_s || tx_abort_s) begin
            retry_d      = {RTW{1'b0}};
            retry_pend_d = 1'b0;
        end else begin
            retry_d      = retry_q;
            retry_pend_d = retry_pend_q;
        end

        if (tx_abort_s) begin
            err_d = 1'b1;
        end else if (bus.ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (tx_ok_s) begin
            tx_count_d = tx_count_q + 16'd1;
        end else begin
            tx_count_d = tx_count_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            end_q         <= 1'b0;
            end_prev_q    <= 1'b0;
            refresh_tmr_q <= {RFW{1'b0}};
            refresh_due_q <= 1'b0;
            tmo_q         <= {TOW{1'b0}};
            gap_q         <= {GPW{1'b0}};
            retry_q       <= {RTW{1'b0}};
            retry_pend_q  <= 1'b0;
            err_q         <= 1'b0;
            tx_count_q    <= 16'd0;
            we_a_q        <= 1'b0;
            host_ack_q    <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            add_a_q       <= 3'd0;
            dat_a_q       <= 8'd0;
        end else begin
            end_q         <= end_d;
            end_prev_q    <= end_prev_d;
            refresh_tmr_q <= refresh_tmr_d;
            refresh_due_q <= refresh_due_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            retry_q       <= retry_d;
            retry_pend_q  <= retry_pend_d;
            err_q         <= err_d;
            tx_count_q    <= tx_count_d;
            we_a_q        <= we_a_d;
            host_ack_q    <= host_ack_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            add_a_q       <= add_a_d;
            dat_a_q       <= dat_a_d;
        end
    end

    assign bus.WE_A     = we_a_q;
    assign bus.HOST_ACK = host_ack_q;
    assign bus.TX_START = tx_start_q;
    assign bus.BUSY     = busy_q;
    assign bus.ADD_A    = add_a_q;
    assign bus.DAT_A    = dat_a_q;
    assign bus.ERR      = err_q;
    assign bus.TX_COUNT = tx_count_q;
endmodule

// File: tb/tb_config_tx_sched.sv
// Directed/randomized bench for config_tx_sched: a serializer model answers START after a
// random latency; expected timing is derived arithmetically from the sequencing rules.
module tb_config_tx_sched;
    localparam int R  = 1000;
    localparam int T  = 200;
    localparam int G  = 4;
    localparam int MR = 2;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic ser_end    = 1'b0;
    logic man_end    = 1'b0;
    int   ser_lat    = 0;
    int   ser_k      = 0;
    int   cyc        = 0;
    logic prev_start = 1'b0;
    int   rise_cyc_q[$];
    int   fall_cyc_q[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;

    config_tx_sched_if bus ();
    assign bus.TX_END = ser_end | man_end;

    config_tx_sched #(
        .REFRESH_CYCLES(R),
        .TIMEOUT_CYCLES(T),
        .GAP_CYCLES    (G),
        .MAX_RETRY     (MR)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer: raises END after ser_lat sampled START cycles (0 = never answers)
    always @(negedge clk) begin
        if (bus.TX_START) begin
            ser_k <= ser_k + 1;
            if (ser_lat != 0 && ser_k + 1 == ser_lat) ser_end <= 1'b1;
        end else begin
            ser_k   <= 0;
            ser_end <= 1'b0;
        end
    end

    // START edge recorder, timestamps in posedge counts
    always @(negedge clk) begin
        prev_start <= bus.TX_START;
        if (bus.TX_START && !prev_start) rise_cyc_q.push_back(cyc);
        if (!bus.TX_START && prev_start) fall_cyc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic host_req(input logic [2:0] a, input logic [7:0] d, input int budget,
                            output int ack_at, output logic [2:0] a_seen,
                            output logic [7:0] d_seen, output logic we_seen);
        ack_at  = -1;
        a_seen  = 3'd0;
        d_seen  = 8'd0;
        we_seen = 1'b0;
        bus.HOST_ADDR = a;
        bus.HOST_DATA = d;
        bus.HOST_REQ  = 1'b1;
        for (int i = 0; i < budget && ack_at < 0; i++) begin
            step();
            if (bus.HOST_ACK) begin
                ack_at  = cyc;
                a_seen  = bus.ADD_A;
                d_seen  = bus.DAT_A;
                we_seen = bus.WE_A;
            end
        end
        bus.HOST_REQ = 1'b0;
        chk("host_ack_seen", ack_at >= 0, 1'b1);
    endtask

    task automatic wait_q(input bit want_rise, input int target, input int budget);
        int n;
        n = want_rise ? rise_cyc_q.size() : fall_cyc_q.size();
        for (int i = 0; i < budget && n < target; i++) begin
            step();
            n = want_rise ? rise_cyc_q.size() : fall_cyc_q.size();
        end
        if (want_rise) chk("start_rise_seen", n >= target, 1'b1);
        else           chk("start_fall_seen", n >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            if (!bus.BUSY) at = cyc;
            else step();
        end
        chk("busy_low", bus.BUSY, 1'b0);
    endtask

    initial begin
        int ack_at, idle_at, br, bf, exp_cnt, exp_rise, c0, p3, req_at, n_before;
        logic [2:0] a_s, a2;
        logic [7:0] d_s, d2;
        logic we_s;
        exp_cnt = 0;
        bus.HOST_REQ = 1'b0; bus.HOST_ADDR = 3'd0; bus.HOST_DATA = 8'd0;
        bus.REFRESH_EN = 1'b0; bus.ERR_CLR = 1'b0;

        // Reset state
        step(3);
        chk("rst_we", bus.WE_A, 1'b0);       chk("rst_ack", bus.HOST_ACK, 1'b0);
        chk("rst_start", bus.TX_START, 1'b0); chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_err", bus.ERR, 1'b0);       chk("rst_add", bus.ADD_A, 3'd0);
        chk("rst_dat", bus.DAT_A, 8'd0);     chk("rst_count", bus.TX_COUNT, 16'd0);
        rst = 1'b0;
        step(2);

        // Host write: WE/ACK one cycle after REQ, START one cycle later
        ser_lat = $urandom_range(20, 120);
        br = rise_cyc_q.size(); bf = fall_cyc_q.size(); req_at = cyc;
        host_req(3'd3, 8'hA5, 4, ack_at, a_s, d_s, we_s);
        chk("w_ack_lat", ack_at, req_at + 1);
        chk("w_we", we_s, 1'b1); chk("w_add", a_s, 3'd3); chk("w_dat", d_s, 8'hA5);
        step();
        chk("w_we_pulse", bus.WE_A, 1'b0); chk("w_ack_pulse", bus.HOST_ACK, 1'b0);
        chk("w_start", bus.TX_START, 1'b1); chk("w_busy", bus.BUSY, 1'b1);
        wait_q(1'b0, bf + 1, 300);
        wait_idle(G + 10, idle_at);
        exp_cnt++;
        chk("w_rise_cyc", rise_cyc_q[br], req_at + 2);
        chk("w_hi_len", fall_cyc_q[bf] - rise_cyc_q[br], ser_lat + 1);
        chk("w_gap_idle", idle_at - fall_cyc_q[bf], G);
        chk("w_count", bus.TX_COUNT, exp_cnt);

        // Random host writes; first one answers in the timeout cycle (still success)
        for (int i = 0; i < 4; i++) begin
            ser_lat = (i == 0) ? T - 1 : $urandom_range(5, 150);
            a2 = 3'($urandom_range(0, 7)); d2 = 8'($urandom_range(0, 255));
            br = rise_cyc_q.size(); bf = fall_cyc_q.size(); req_at = cyc;
            host_req(a2, d2, 4, ack_at, a_s, d_s, we_s);
            chk("r_ack_lat", ack_at, req_at + 1);
            chk("r_add", a_s, a2); chk("r_dat", d_s, d2);
            wait_q(1'b0, bf + 1, T + 20);
            wait_idle(G + 10, idle_at);
            exp_cnt++;
            chk("r_hi_len", fall_cyc_q[bf] - rise_cyc_q[br], ser_lat + 1);
            chk("r_gap_idle", idle_at - fall_cyc_q[bf], G);
            chk("r_count", bus.TX_COUNT, exp_cnt);
        end

        // Periodic refresh
        bus.REFRESH_EN = 1'b1;
        exp_rise = cyc + R;
        for (int i = 0; i < 3; i++) begin
            ser_lat = $urandom_range(10, 150);
            br = rise_cyc_q.size(); bf = fall_cyc_q.size();
            wait_q(1'b1, br + 1, R + 400);
            chk("ref_rise_cyc", rise_cyc_q[br], exp_rise);
            wait_q(1'b0, bf + 1, 300);
            exp_cnt++;
            chk("ref_hi_len", fall_cyc_q[bf] - rise_cyc_q[br], ser_lat + 1);
            chk("ref_count", bus.TX_COUNT, exp_cnt);
            exp_rise = exp_rise + ser_lat + R + 1;
        end
        bus.REFRESH_EN = 1'b0;
        wait_idle(G + 10, idle_at);

        // Timeout with retries, ERR_CLR coinciding with the abort, then clear
        ser_lat = 0;
        br = rise_cyc_q.size(); bf = fall_cyc_q.size();
        host_req(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4, ack_at, a_s, d_s, we_s);
        wait_q(1'b1, br + MR + 1, (MR + 1) * (T + G) + 20);
        p3 = rise_cyc_q[br + MR];
        while (cyc < p3 + T - 1) step();
        chk("to_err_before", bus.ERR, 1'b0);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("to_err_set_wins", bus.ERR, 1'b1);
        chk("to_start_low", bus.TX_START, 1'b0);
        wait_idle(G + 10, idle_at);
        step(20);
        chk("to_pulses", rise_cyc_q.size() - br, MR + 1);
        for (int i = 0; i <= MR; i++)
            chk("to_hi_len", fall_cyc_q[bf + i] - rise_cyc_q[br + i], T);
        for (int i = 0; i < MR; i++)
            chk("to_lo_len", rise_cyc_q[br + i + 1] - fall_cyc_q[bf + i], G);
        chk("to_count", bus.TX_COUNT, exp_cnt);
        chk("to_err_sticky", bus.ERR, 1'b1);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("to_err_clr", bus.ERR, 1'b0);

        // Host request collides with a pending refresh
        ser_lat = $urandom_range(20, 120);
        bus.REFRESH_EN = 1'b1;
        c0 = cyc;
        while (cyc < c0 + R - 1) step();
        br = rise_cyc_q.size(); bf = fall_cyc_q.size();
        a2 = 3'($urandom_range(0, 7)); d2 = 8'($urandom_range(0, 255));
        host_req(a2, d2, 4, ack_at, a_s, d_s, we_s);
        chk("col_host_first", ack_at, c0 + R);
        chk("col_add", a_s, a2); chk("col_dat", d_s, d2);
        wait_q(1'b0, bf + 1, 300);
        exp_cnt++;
        chk("col_rise_cyc", rise_cyc_q[br], c0 + R + 1);
        chk("col_count", bus.TX_COUNT, exp_cnt);
        wait_q(1'b1, br + 2, R + 400);
        chk("col_next_refresh", rise_cyc_q[br + 1], c0 + R + 1 + ser_lat + R + 1);
        wait_q(1'b0, bf + 2, 300);
        exp_cnt++;
        chk("col_count2", bus.TX_COUNT, exp_cnt);
        bus.REFRESH_EN = 1'b0;
        wait_idle(G + 10, idle_at);

        // Host request while busy is held off until the gap ends
        ser_lat = $urandom_range(60, 120);
        br = rise_cyc_q.size(); bf = fall_cyc_q.size();
        host_req(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4, ack_at, a_s, d_s, we_s);
        step(10);
        n_before = fall_cyc_q.size();
        a2 = 3'($urandom_range(0, 7)); d2 = 8'($urandom_range(0, 255));
        host_req(a2, d2, 300, ack_at, a_s, d_s, we_s);
        chk("busy_no_early_ack", n_before, bf);
        chk("busy_ack_cyc", ack_at, fall_cyc_q[bf] + G + 1);
        chk("busy_add", a_s, a2); chk("busy_dat", d_s, d2);
        wait_q(1'b0, bf + 2, 300);
        exp_cnt += 2;
        chk("busy_rise2", rise_cyc_q[br + 1], ack_at + 1);
        chk("busy_count", bus.TX_COUNT, exp_cnt);
        wait_idle(G + 10, idle_at);

        // Reset in WAIT_END; a late END edge is ignored
        ser_lat = 0;
        host_req(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 4, ack_at, a_s, d_s, we_s);
        step(20);
        chk("mrst_start_before", bus.TX_START, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_start", bus.TX_START, 1'b0);
        chk("mrst_count", bus.TX_COUNT, 16'd0);
        chk("mrst_busy", bus.BUSY, 1'b0);
        man_end = 1'b1;
        step(5);
        chk("late_end_busy", bus.BUSY, 1'b0);
        chk("late_end_count", bus.TX_COUNT, 16'd0);
        chk("late_end_start", bus.TX_START, 1'b0);
        man_end = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
